rv32_decode: RTL and testbench

Decode stage of the rv32 pipeline, between fetch and execute, and the direct upstream driver of the register file. It presents rs1/rs2 indices combinationally to the register file so that registered read data lands in the same cycle as this block's registered decode outputs. It decodes RV32I into control fields, inserts a one-cycle bubble on load-use hazards, and honours pipeline stall and flush.

---
 rtl/rv32_pkg.sv | 66 ++++++
 rtl/rv32_imm_gen.sv | 23 ++
 rtl/rv32_decode.sv | 228 ++++++++++++++++++++++
 tb/tb_rv32_decode.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: opcodes, ALU/branch/memory-width encodings and the per-instruction control bundle.
// Nothing here holds state; the decode stage and immediate generator import it.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_SRC2
  } alu_op_t;

  // Nine distinct branch kinds, so the encoding needs four bits.
  typedef enum logic [3:0] {
    BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } branch_op_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic       rd_write;
    logic       src1_pc;
    logic       src2_imm;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_width;
    logic       mem_unsigned;
    alu_op_t    alu_op;
    branch_op_t branch_op;
    imm_fmt_t   imm_fmt;
    logic       uses_rs1;
    logic       uses_rs2;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32 immediate extraction and sign extension for the I/S/B/U/J formats.
// Zero latency, no flow control; formats without an immediate produce zero.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    case (fmt)
      IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32_decode.sv
// RV32I decode stage: one-cycle registered decode aligned with register-file reads, one-bubble load-use interlock.
// stall_in freezes all outputs, flush_in kills the entering instruction; RV32_ILLEGAL_INSTR_EN adds illegal_out checks.
module rv32_decode
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [4:0]  rs1_unreg_out,
  output logic [4:0]  rs2_unreg_out,
  output logic        regs_stall_out,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] imm_out,
  output logic [3:0]  alu_op_out,
  output logic        src1_pc_out,
  output logic        src2_imm_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_width_out,
  output logic        mem_unsigned_out,
  output logic [3:0]  branch_op_out,
  output logic        illegal_out
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  ctrl_t       ctrl;
  logic        dec_kill;
  logic        hazard;
  logic        bubble;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign rd     = instr_in[11:7];

  assign rs1_unreg_out  = rs1;
  assign rs2_unreg_out  = rs2;
  assign regs_stall_out = stall_in;

  always_comb begin
    ctrl           = '0;
    ctrl.alu_op    = ALU_ADD;
    ctrl.branch_op = BR_NONE;
    ctrl.imm_fmt   = IMM_NONE;
    ctrl.uses_rs1  = 1'b1;
    case (opcode)
      OPC_LUI: begin
        ctrl.uses_rs1 = 1'b0;
        ctrl.rd_write = 1'b1;
        ctrl.imm_fmt  = IMM_U;
        ctrl.src2_imm = 1'b1;
        ctrl.alu_op   = ALU_SRC2;
      end
      OPC_AUIPC: begin
        ctrl.uses_rs1 = 1'b0;
        ctrl.rd_write = 1'b1;
        ctrl.imm_fmt  = IMM_U;
        ctrl.src1_pc  = 1'b1;
        ctrl.src2_imm = 1'b1;
      end
      // Jumps: the ALU forms the link value pc+4, imm carries the target offset.
      OPC_JAL: begin
        ctrl.uses_rs1  = 1'b0;
        ctrl.rd_write  = 1'b1;
        ctrl.imm_fmt   = IMM_J;
        ctrl.src1_pc   = 1'b1;
        ctrl.branch_op = BR_JAL;
      end
      OPC_JALR: begin
        ctrl.rd_write  = 1'b1;
        ctrl.imm_fmt   = IMM_I;
        ctrl.src1_pc   = 1'b1;
        ctrl.branch_op = BR_JALR;
      end
      OPC_BRANCH: begin
        ctrl.uses_rs2 = 1'b1;
        ctrl.imm_fmt  = IMM_B;
        case (funct3)
          3'b000:  ctrl.branch_op = BR_BEQ;
          3'b001:  ctrl.branch_op = BR_BNE;
          3'b100:  ctrl.branch_op = BR_BLT;
          3'b101:  ctrl.branch_op = BR_BGE;
          3'b110:  ctrl.branch_op = BR_BLTU;
          3'b111:  ctrl.branch_op = BR_BGEU;
          default: ctrl.branch_op = BR_NONE;
        endcase
      end
      OPC_LOAD: begin
        ctrl.rd_write     = 1'b1;
        ctrl.imm_fmt      = IMM_I;
        ctrl.src2_imm     = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.mem_width    = funct3[1:0];
        ctrl.mem_unsigned = funct3[2];
      end
      OPC_STORE: begin
        ctrl.uses_rs2  = 1'b1;
        ctrl.imm_fmt   = IMM_S;
        ctrl.src2_imm  = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_width = funct3[1:0];
      end
      OPC_OP_IMM: begin
        ctrl.rd_write = 1'b1;
        ctrl.imm_fmt  = IMM_I;
        ctrl.src2_imm = 1'b1;
        ctrl.alu_op   = alu_decode(funct3, (funct3 == 3'b101) && instr_in[30]);
      end
      OPC_OP: begin
        ctrl.uses_rs2 = 1'b1;
        ctrl.rd_write = 1'b1;
        ctrl.alu_op   = alu_decode(funct3, instr_in[30]);
      end
      default: ;  // FENCE, SYSTEM and unknown opcodes pass through as NOPs
    endcase
  end

  rv32_imm_gen u_imm_gen (
    .instr (instr_in),
    .fmt   (ctrl.imm_fmt),
    .imm   (imm)
  );

  // Only a load still sitting in our output stage can collide; one bubble lets it reach MEM.
  assign hazard = valid_out && mem_read_out && (rd_out != 5'd0) && valid_in &&
                  ((ctrl.uses_rs1 && (rs1 == rd_out)) || (ctrl.uses_rs2 && (rs2 == rd_out)));
  assign stall_out = stall_in || (hazard && !flush_in);
  assign bubble    = flush_in || (!stall_in && hazard);

`ifdef RV32_ILLEGAL_INSTR_EN
  logic       illegal;
  logic [6:0] funct7;

  assign funct7 = instr_in[31:25];

  always_comb begin
    illegal = (instr_in[1:0] != 2'b11);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: ;
      OPC_BRANCH: illegal |= funct3 inside {3'b010, 3'b011};
      OPC_LOAD:   illegal |= funct3 inside {3'b011, 3'b110, 3'b111};
      OPC_STORE:  illegal |= (funct3 > 3'b010);
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          illegal |= (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          illegal |= !(funct7 inside {7'h00, 7'h20});
      end
      OPC_OP: illegal |= !((funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && (funct3 inside {3'b000, 3'b101})));
      default: illegal = 1'b1;
    endcase
  end

  assign dec_kill = illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_out <= 1'b0;
    else if (bubble)
      illegal_out <= 1'b0;
    else if (!stall_in)
      illegal_out <= valid_in && illegal;
  end
`else
  assign dec_kill    = 1'b0;
  assign illegal_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out        <= 1'b0;
      pc_out           <= RESET_PC;
      rs1_out          <= 5'd0;
      rs2_out          <= 5'd0;
      rd_out           <= 5'd0;
      rd_write_out     <= 1'b0;
      imm_out          <= 32'h0;
      alu_op_out       <= ALU_ADD;
      src1_pc_out      <= 1'b0;
      src2_imm_out     <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      mem_width_out    <= 2'd0;
      mem_unsigned_out <= 1'b0;
      branch_op_out    <= BR_NONE;
    end else if (bubble) begin
      valid_out     <= 1'b0;
      rd_write_out  <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      branch_op_out <= BR_NONE;
    end else if (!stall_in) begin
      valid_out        <= valid_in;
      pc_out           <= pc_in;
      rs1_out          <= rs1;
      rs2_out          <= rs2;
      rd_out           <= rd;
      imm_out          <= imm;
      alu_op_out       <= ctrl.alu_op;
      src1_pc_out      <= ctrl.src1_pc;
      src2_imm_out     <= ctrl.src2_imm;
      mem_width_out    <= ctrl.mem_width;
      mem_unsigned_out <= ctrl.mem_unsigned;
      rd_write_out     <= valid_in && !dec_kill && ctrl.rd_write && (rd != 5'd0);
      mem_read_out     <= valid_in && !dec_kill && ctrl.mem_read;
      mem_write_out    <= valid_in && !dec_kill && ctrl.mem_write;
      branch_op_out    <= valid_in ? ctrl.branch_op : BR_NONE;
    end
  end

endmodule

// File: tb/tb_rv32_decode.sv
// Directed and randomized checks of rv32_decode against an instruction-level reference model.
module tb_rv32_decode;
  import rv32_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [3:0] ALU_TBL [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                         ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [3:0] BR_TBL [8] = '{BR_BEQ, BR_BNE, BR_NONE, BR_NONE,
                                        BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
  localparam logic [6:0] OPC_TBL [13] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                          OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
                                          OPC_MISC_MEM, OPC_SYSTEM, 7'h7F, 7'h0B};
`ifdef RV32_ILLEGAL_INSTR_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, stall_in, flush_in, valid_in;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  rs1_unreg_out, rs2_unreg_out, rs1_out, rs2_out, rd_out;
  logic        regs_stall_out, stall_out, valid_out, rd_write_out, src1_pc_out, src2_imm_out;
  logic        mem_read_out, mem_write_out, mem_unsigned_out, illegal_out;
  logic [31:0] pc_out, imm_out;
  logic [3:0]  alu_op_out, branch_op_out;
  logic [1:0]  mem_width_out;

  always #5 clk = ~clk;

  rv32_decode #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .rs1_unreg_out(rs1_unreg_out), .rs2_unreg_out(rs2_unreg_out),
    .regs_stall_out(regs_stall_out), .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
    .imm_out(imm_out), .alu_op_out(alu_op_out), .src1_pc_out(src1_pc_out),
    .src2_imm_out(src2_imm_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_width_out(mem_width_out), .mem_unsigned_out(mem_unsigned_out),
    .branch_op_out(branch_op_out), .illegal_out(illegal_out)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_write;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src1_pc, src2_imm, mem_read, mem_write;
    logic [1:0]  mem_width;
    logic        mem_unsigned;
    logic [3:0]  branch;
    logic        illegal;
  } mstate_t;

  int checks = 0;
  int errors = 0;
  mstate_t m;
  logic last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s = '0;
    s.pc     = RST_PC;
    s.alu    = ALU_ADD;
    s.branch = BR_NONE;
    return s;
  endfunction

  function automatic mstate_t killed(input mstate_t s);
    mstate_t k = s;
    k.valid = 1'b0; k.rd_write = 1'b0; k.mem_read = 1'b0; k.mem_write = 1'b0;
    k.branch = BR_NONE; k.illegal = 1'b0;
    return k;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC: return ins & 32'hFFFF_F000;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: return 32'($signed(ins) >>> 20);
      OPC_STORE: return (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
      OPC_BRANCH: return (ins[31] ? 32'hFFFF_F000 : 32'h0) + 32'(ins[7]) * 32'd2048 +
                         32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
      OPC_JAL: return (ins[31] ? 32'hFFF0_0000 : 32'h0) + 32'(ins[19:12]) * 32'd4096 +
                      32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [2:0] f3 = ins[14:12];
    logic [3:0] op = ALU_TBL[f3];
    if (ins[6:0] == OPC_LUI) return ALU_SRC2;
    if (ins[6:0] == OPC_OP) begin
      if (ins[30] && f3 == 3'd0) op = ALU_SUB;
      if (ins[30] && f3 == 3'd5) op = ALU_SRA;
      return op;
    end
    if (ins[6:0] == OPC_OP_IMM) begin
      if (ins[30] && f3 == 3'd5) op = ALU_SRA;
      return op;
    end
    return ALU_ADD;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (!ILL_EN) return 1'b0;
    if (ins[1:0] != 2'b11) return 1'b1;
    case (ins[6:0])
      OPC_LOAD:   return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      OPC_STORE:  return !(f3 inside {3'd0, 3'd1, 3'd2});
      OPC_BRANCH: return f3 inside {3'd2, 3'd3};
      OPC_OP_IMM: return (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      OPC_OP:     return !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic mstate_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    mstate_t s;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    s.valid = v; s.pc = pc;
    s.rs1 = ins[19:15]; s.rs2 = ins[24:20]; s.rd = ins[11:7];
    s.imm = ref_imm(ins);
    s.alu = ref_alu(ins);
    s.src1_pc  = opc inside {OPC_AUIPC, OPC_JAL, OPC_JALR};
    s.src2_imm = opc inside {OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_OP_IMM};
    s.mem_width    = (opc inside {OPC_LOAD, OPC_STORE}) ? f3[1:0] : 2'd0;
    s.mem_unsigned = (opc == OPC_LOAD) && f3[2];
    s.illegal   = ref_illegal(ins);
    s.rd_write  = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP})
                  && s.rd != 5'd0 && !s.illegal;
    s.mem_read  = (opc == OPC_LOAD) && !s.illegal;
    s.mem_write = (opc == OPC_STORE) && !s.illegal;
    s.branch    = (opc == OPC_JAL) ? BR_JAL : (opc == OPC_JALR) ? BR_JALR :
                  (opc == OPC_BRANCH) ? BR_TBL[f3] : BR_NONE;
    if (!v) s = killed(s);
    return s;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] ins, input logic v);
    logic uses1 = !(ins[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    logic uses2 = ins[6:0] inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    return m.valid && m.mem_read && m.rd != 5'd0 && v &&
           ((uses1 && ins[19:15] == m.rd) || (uses2 && ins[24:20] == m.rd));
  endfunction

  task automatic check_regs();
    chk("valid_out", 32'(valid_out), 32'(m.valid));
    chk("pc_out", pc_out, m.pc);
    chk("rs1_out", 32'(rs1_out), 32'(m.rs1));
    chk("rs2_out", 32'(rs2_out), 32'(m.rs2));
    chk("rd_out", 32'(rd_out), 32'(m.rd));
    chk("rd_write_out", 32'(rd_write_out), 32'(m.rd_write));
    chk("imm_out", imm_out, m.imm);
    chk("alu_op_out", 32'(alu_op_out), 32'(m.alu));
    chk("src1_pc_out", 32'(src1_pc_out), 32'(m.src1_pc));
    chk("src2_imm_out", 32'(src2_imm_out), 32'(m.src2_imm));
    chk("mem_read_out", 32'(mem_read_out), 32'(m.mem_read));
    chk("mem_write_out", 32'(mem_write_out), 32'(m.mem_write));
    chk("mem_width_out", 32'(mem_width_out), 32'(m.mem_width));
    chk("mem_unsigned_out", 32'(mem_unsigned_out), 32'(m.mem_unsigned));
    chk("branch_op_out", 32'(branch_op_out), 32'(m.branch));
    chk("illegal_out", 32'(illegal_out), 32'(m.illegal));
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic st, input logic fl);
    logic hz;
    mstate_t nxt;
    @(negedge clk);
    valid_in = v; pc_in = pc; instr_in = ins; stall_in = st; flush_in = fl;
    #1;
    hz = ref_hazard(ins, v);
    last_stall = stall_out;
    chk("rs1_unreg_out", 32'(rs1_unreg_out), 32'(ins[19:15]));
    chk("rs2_unreg_out", 32'(rs2_unreg_out), 32'(ins[24:20]));
    chk("regs_stall_out", 32'(regs_stall_out), 32'(st));
    chk("stall_out", 32'(stall_out), 32'(st || (hz && !fl)));
    if (fl || (!st && hz)) nxt = killed(m);
    else if (st)           nxt = m;
    else                   nxt = ref_decode(ins, pc, v);
    @(posedge clk);
    #1;
    m = nxt;
    check_regs();
  endtask

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    logic [31:0] ins, pc;
    logic v, st, fl;
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
    pc_in = 32'h0; instr_in = 32'h0;
    m = reset_state();
    #12;
    check_regs();
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);          // ADDI x1,x0,5
    chk("addi_valid", 32'(valid_out), 32'd1);
    chk("addi_imm", imm_out, 32'd5);
    chk("addi_alu", 32'(alu_op_out), 32'(ALU_ADD));
    chk("addi_src2_imm", 32'(src2_imm_out), 32'd1);
    chk("addi_pc", pc_out, 32'h100);

    step(1'b1, 32'h104, 32'h0000A103, 1'b0, 1'b0);          // LW x2,0(x1)
    step(1'b1, 32'h108, 32'h001101B3, 1'b0, 1'b0);          // ADD x3,x2,x1
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(valid_out), 32'd0);
    step(1'b1, 32'h108, 32'h001101B3, 1'b0, 1'b0);
    chk("lu_release", 32'(last_stall), 32'd0);
    chk("lu_add_valid", 32'(valid_out), 32'd1);
    chk("lu_add_rs1", 32'(rs1_out), 32'd2);
    chk("lu_add_rs2", 32'(rs2_out), 32'd1);

    step(1'b1, 32'h10C, 32'h0000A003, 1'b0, 1'b0);          // LW x0,0(x1)
    step(1'b1, 32'h110, 32'h001001B3, 1'b0, 1'b0);          // ADD x3,x0,x1
    chk("x0_no_stall", 32'(last_stall), 32'd0);
    chk("x0_add_valid", 32'(valid_out), 32'd1);

    step(1'b1, 32'h114, 32'h00000013, 1'b0, 1'b0);          // ADDI x0,x0,0
    chk("nop_rd_write", 32'(rd_write_out), 32'd0);

    step(1'b1, 32'h118, 32'hFE000EE3, 1'b0, 1'b0);          // BEQ x0,x0,-4
    chk("beq_imm", imm_out, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(branch_op_out), 32'(BR_BEQ));
    step(1'b1, 32'h11C, 32'h00500093, 1'b1, 1'b1);          // flush with stall
    chk("flush_stall_valid", 32'(valid_out), 32'd0);
    chk("flush_stall_branch", 32'(branch_op_out), 32'(BR_NONE));
    step(1'b1, 32'h120, 32'h00500093, 1'b1, 1'b0);          // plain stall holds
    chk("stall_hold_pc", pc_out, 32'h118);

    step(1'b1, 32'h124, 32'h0000007F, 1'b0, 1'b0);          // unknown opcode
    chk("unk_illegal", 32'(illegal_out), 32'(ILL_EN));
    chk("unk_rd_write", 32'(rd_write_out), 32'd0);
    chk("unk_valid", 32'(valid_out), 32'd1);

    step(1'b1, 32'h128, 32'h00500093, 1'b0, 1'b0);
    #2;
    reset = 1'b1;                                           // asynchronous, mid-cycle
    #1;
    chk("async_rst_valid", 32'(valid_out), 32'd0);
    chk("async_rst_pc", pc_out, RST_PC);
    m = reset_state();
    check_regs();
    @(negedge clk);
    reset = 1'b0;

    ins = 32'h0;
    pc = 32'h200;
    for (int i = 0; i < 600; i++) begin
      if (!(last_stall && $urandom_range(0, 1) == 0)) begin
        ins = $urandom;
        ins[6:0]   = OPC_TBL[$urandom_range(0, 12)];
        if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h20;
          default: ;
        endcase
        pc = pc + 32'd4;
      end
      v  = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 11) == 0);
      step(v, pc, ins, st, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
